// File: rtl/seg7_scan.sv
// Two-digit multiplexed 7-segment hex display fed from an 8-bit count; one value snapshot per frame.
// Optional leading-zero blanking of the high digit when SEG7_LZB_EN is defined.
module seg7_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int GAP_CYC  = 16,
    parameter bit CA       = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    output logic [6:0] hex,
    output logic [1:0] dig,
    output logic       frame
);

    localparam int MAX_DUR = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
    localparam int CW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [6:0] HEX_OFF = CA ? 7'h7F : 7'h00;
    localparam logic [1:0] DIG_OFF = CA ? 2'b11 : 2'b00;

    typedef enum logic [1:0] {S_D0, S_GAP0, S_D1, S_GAP1} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [7:0]    r_snap;
    logic          w_last;
    logic          w_blank1;
    logic [6:0]    w_hex_ah;
    logic [1:0]    w_dig_ah;
    logic          w_frame_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

`ifdef SEG7_LZB_EN
    assign w_blank1 = (r_snap[7:4] == 4'h0);
`else
    assign w_blank1 = 1'b0;
`endif

    // Next-state: each state holds for its duration, then the fixed cycle advances.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_last      = (r_state == S_D0 || r_state == S_D1) ? (r_cnt == SCAN_LAST)
                                                          : (r_cnt == GAP_LAST);
        if (w_last) begin
            w_cnt_nxt = '0;
            case (r_state)
                S_D0:    w_state_nxt = S_GAP0;
                S_GAP0:  w_state_nxt = S_D1;
                S_D1:    w_state_nxt = S_GAP1;
                default: w_state_nxt = S_D0;
            endcase
        end
    end

    // Output decode in active-high form; polarity applied when loading the output flops.
    always_comb begin
        w_hex_ah    = 7'h00;
        w_dig_ah    = 2'b00;
        w_frame_nxt = (r_state == S_D0) && (r_cnt == '0);
        case (r_state)
            S_D0: begin
                w_dig_ah = 2'b01;
                w_hex_ah = seg_decode(r_snap[3:0]);
            end
            S_D1: begin
                if (!w_blank1) begin
                    w_dig_ah = 2'b10;
                    w_hex_ah = seg_decode(r_snap[7:4]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_GAP1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap <= 8'h00;
            hex    <= HEX_OFF;
            dig    <= DIG_OFF;
            frame  <= 1'b0;
        end else begin
            if (r_state == S_GAP1 && w_last)
                r_snap <= value;
            hex   <= CA ? ~w_hex_ah : w_hex_ah;
            dig   <= CA ? ~w_dig_ah : w_dig_ah;
            frame <= w_frame_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: frame-position model derived from edge count since reset release,
// plus literal pins on specific cycles.
module tb_seg7_scan;

    localparam int SD = 4;
    localparam int GC = 1;
    localparam int P  = 2 * SD + 2 * GC;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] value;
    logic [6:0] hex;
    logic [1:0] dig;
    logic       frame;

    int n_cmp = 0;
    int n_err = 0;
    int k     = 0;
    logic [7:0] vhist [0:4095];
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_scan #(.SCAN_DIV(SD), .GAP_CYC(GC), .CA(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .hex   (hex),
        .dig   (dig),
        .frame (frame)
    );

    always #5 clk = ~clk;

    // Edge count since reset release and the value present at each edge.
    always @(posedge clk) begin
        if (reset) k = 0;
        else begin
            k = k + 1;
            if (k < 4096) vhist[k] = value;
        end
    end

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d got {frame,dig,hex}=%03h expected %03h", nm, k, act, exp);
        end
    endtask

    // Expected outputs (common anode) from position within the frame.
    function automatic logic [9:0] model_out();
        logic [6:0] h;
        logic [1:0] d;
        logic       f;
        logic [7:0] snap;
        int fi, p;
        h = 7'h00; d = 2'b00; f = 1'b0;
        if (!reset && k >= GC + 1) begin
            fi   = (k - GC - 1) / P;
            p    = (k - GC - 1) % P;
            snap = vhist[GC + fi * P];
            f    = (p == 0);
            if (p < SD) begin
                d = 2'b01; h = seg_tab[snap[3:0]];
            end else if (p >= SD + GC && p < 2 * SD + GC) begin
`ifdef SEG7_LZB_EN
                if (snap[7:4] != 4'h0) begin
                    d = 2'b10; h = seg_tab[snap[7:4]];
                end
`else
                d = 2'b10; h = seg_tab[snap[7:4]];
`endif
            end
        end
        return {f, ~d, ~h};
    endfunction

    always @(posedge clk) begin
        #2;
        chk("model", {frame, dig, hex}, model_out());
    end

    task automatic pin_at(input int kk, input logic [6:0] eh, input logic [1:0] ed,
                          input logic ef, input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (k != kk && n < 300);
        if (k != kk) begin
            n_cmp++; n_err++;
            $display("FAIL %s timeout k=%0d wanted %0d", nm, k, kk);
        end else begin
            chk(nm, {frame, dig, hex}, {ef, ed, eh});
        end
    endtask

    initial begin
        int n;
        reset = 1'b0;
        value = 8'hA5;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_hold", {frame, dig, hex}, {1'b0, 2'b11, 7'h7F});
        value = 8'h3C;
        reset = 1'b0;

        pin_at(2,  7'h46, 2'b10, 1'b1, "d0_C_first_frame");
        pin_at(6,  7'h7F, 2'b11, 1'b0, "gap0");
        pin_at(7,  7'h30, 2'b01, 1'b0, "d1_3");
        pin_at(11, 7'h7F, 2'b11, 1'b0, "gap1");
        pin_at(12, 7'h46, 2'b10, 1'b1, "frame2");
        @(negedge clk);
        value = 8'h81;
        pin_at(17, 7'h30, 2'b01, 1'b0, "d1_holds_3");
        pin_at(22, 7'h79, 2'b10, 1'b1, "d0_1_next");
        pin_at(27, 7'h00, 2'b01, 1'b0, "d1_8_next");

        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            value = value + 8'h01;
        end

        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (((k - GC - 1) % P) != SD + GC + 1 && n < 100);
        @(negedge clk);
        reset = 1'b1;
        value = 8'h07;
        #1;
        chk("async_reset_mid_d1", {frame, dig, hex}, {1'b0, 2'b11, 7'h7F});
        repeat (3) @(negedge clk);
        reset = 1'b0;
        pin_at(2, 7'h78, 2'b10, 1'b1, "after_reset_d0_7");
`ifdef SEG7_LZB_EN
        pin_at(7, 7'h7F, 2'b11, 1'b0, "lzb_d1_blank");
`else
        pin_at(7, 7'h40, 2'b01, 1'b0, "d1_0_shown");
`endif
        repeat (25) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
